mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Parametrised N-port memory arbiter that merges the CPU's independent memory ports (instruction fetch, data access, and future requesters) onto one physical memory port using the team's read/write/resp handshake. It sits between the core's memory ports and the shared memory or next-level cache. It generalises the fixed two-port split (port a / port b) to `N_PORTS` requesters with configurable data and address widths. It adds round-robin arbitration, request latching and per-port response routing.

## Interface
- `N_PORTS`, 2: number of upstream requesters (2..8).
- `DATA_WIDTH`, 16: data word width in bits (multiple of 8).
- `ADDR_WIDTH`, 16: address width in bits.
- `MASK_WIDTH`, `DATA_WIDTH/8`: byte write-mask width (derived, not overridden).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `up_read` input `N_PORTS`: per-port read request, held until that port's resp.
- `up_write` input `N_PORTS`: per-port write request, held until that port's resp.
- `up_wmask` input `N_PORTS*MASK_WIDTH`: packed byte masks; port i at `[i*MASK_WIDTH +: MASK_WIDTH]`.
- `up_address` input `N_PORTS*ADDR_WIDTH`: packed addresses.
- `up_wdata` input `N_PORTS*DATA_WIDTH`: packed write data.
- `up_resp` output `N_PORTS`: one-hot, one-cycle completion pulse to the granted port.
- `up_rdata` output `DATA_WIDTH`: read data shared by all ports; valid only with the owning `up_resp` bit.
- `mem_read` output 1: downstream read strobe.
- `mem_write` output 1: downstream write strobe.
- `mem_wmask` output `MASK_WIDTH`: downstream byte mask.
- `mem_address` output `ADDR_WIDTH`: downstream address.
- `mem_wdata` output `DATA_WIDTH`: downstream write data.
- `mem_resp` input 1: downstream completion pulse.
- `mem_rdata` input `DATA_WIDTH`: downstream read data.
- `grant_id` output `$clog2(N_PORTS)`: index of the port owning the current transaction.
- `busy` output 1: high while a transaction is outstanding.

## Operation
- FSM has two states:
  - IDLE: requests are sampled.
  - BUSY: the latched transaction is driven downstream.
- IDLE -> BUSY:
  - Transition occurs when any `up_read[i] | up_write[i]` is high.
  - The winner is chosen by round-robin: search starts at `rr_ptr` and wraps modulo `N_PORTS`.
  - The winner's address, wdata, wmask and op are latched into registers, and `grant_id` is latched.
- BUSY: `mem_*` outputs are driven from the latched registers only. Upstream changes are ignored.
- BUSY -> IDLE:
  - Transition occurs on `mem_resp`.
  - `up_resp[grant_id]` is asserted combinationally in the same cycle.
  - `up_rdata = mem_rdata`, passed straight through.
  - `rr_ptr <= (grant_id + 1) mod N_PORTS`.
- If a port asserts both read and write, write wins and the write is issued.
- If a requester drops its request mid-transaction, the transaction still completes and `up_resp` still pulses.
- `up_rdata` outside a resp cycle mirrors `mem_rdata`. Its value is don't-care there.
- A `mem_resp` received in IDLE is ignored and no `up_resp` is generated.

## Timing
- Reset values:
  - State is IDLE and `rr_ptr = 0`.
  - `mem_read = 0`, `mem_write = 0`, `mem_wmask = 0`, `mem_address = 0`, `mem_wdata = 0`.
  - `grant_id = 0`, `busy = 0`, `up_resp = 0`.
- Request first seen high at cycle T (IDLE): `mem_read`/`mem_write` and `busy` go high at T+1.
- `mem_resp` at cycle R ≥ T+1: `up_resp` pulses at R. `mem_*` strobes and `busy` drop at R+1.
- Minimum upstream latency is 2 cycles (request at T, resp at T+1).
- Dead cycle: one IDLE cycle always separates back-to-back transactions. Each requester deasserts during that cycle, so the same request is never re-granted.
- Reset mid-BUSY:
  - Outputs are forced to their reset values asynchronously.
  - The outstanding transaction is abandoned, and a later `mem_resp` is ignored.
- `grant_id` is held stable from T+1 through R.

## Configuration
- `MEM_ARB_FIXED_PRIORITY_EN`:
  - Defined: fixed priority, lowest index wins (port 0 highest). `rr_ptr` is not implemented and is treated as constant 0.
  - Undefined (default): round-robin as described above.

## Test plan
- Single read: port 1 reads 0x1234 while the memory returns 0xBEEF after 3 cycles.
  - `mem_read`/`mem_address = 0x1234` from T+1.
  - `up_resp = 2'b10` and `up_rdata = 0xBEEF` at the resp cycle.
  - All strobes low at the cycle after resp.
- Contention with round-robin:
  - Stimulus: ports 0 and 1 request every cycle, and each re-requests after its resp.
  - Required: grant order 0,1,0,1.
  - With `MEM_ARB_FIXED_PRIORITY_EN`, grant order is 0,0,0.
- Write with mask:
  - Stimulus: port 0 writes data 0xA5A5 with mask 2'b01 to 0x0040.
  - Required: `mem_write = 1`, `mem_wmask = 01`, `mem_wdata = 0xA5A5`.
  - Required: `up_resp[0]` pulses for one cycle.
- Request change mid-BUSY: port 0 changes its address from 0x0010 to 0x0020 after grant → `mem_address` stays 0x0010 until resp.
- Read+write both high on port 1 → `mem_write = 1`, `mem_read = 0`.
- Reset mid-BUSY:
  - Stimulus: assert `rst` two cycles after grant, then pulse `mem_resp`.
  - Required: all outputs are 0 immediately, no `up_resp` is generated, and the next grant goes to port 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges N_PORTS upstream read/write/resp requesters onto a
// single downstream memory port. Round-robin arbitration by default; define
// MEM_ARB_FIXED_PRIORITY_EN for fixed priority (port 0 highest).
// The winner's request is latched at grant. The latched copy drives the memory
// side until mem_resp arrives. That response is then routed back to the
// winning port in the same cycle.
module mem_port_arbiter #(
  parameter int N_PORTS    = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_PORTS-1:0]               up_read,
  input  logic [N_PORTS-1:0]               up_write,
  input  logic [N_PORTS*MASK_WIDTH-1:0]    up_wmask,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]    up_address,
  input  logic [N_PORTS*DATA_WIDTH-1:0]    up_wdata,
  output logic [N_PORTS-1:0]               up_resp,
  output logic [DATA_WIDTH-1:0]            up_rdata,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [MASK_WIDTH-1:0]            mem_wmask,
  output logic [ADDR_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic                             mem_resp,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic [$clog2(N_PORTS)-1:0]       grant_id,
  output logic                             busy
);

  localparam int GW = $clog2(N_PORTS);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [GW-1:0]         rr_ptr;

  logic [N_PORTS-1:0]    req;
  logic                  found;
  logic [GW-1:0]         winner;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
  // Fixed priority: the search always starts at port 0.
  assign rr_ptr = '0;
`else
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;

  // Round-robin pointer: the port after the last one served gets first look.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == S_BUSY && mem_resp) begin
      rr_ptr_d = (grant_q == GW'(N_PORTS - 1)) ? '0 : grant_q + GW'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;
`endif

  // Pick the first requesting port, searching upward from rr_ptr with wrap.
  always_comb begin
    int idx;
    idx    = 0;
    req    = up_read | up_write;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = (int'(rr_ptr) + k) % N_PORTS;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
  end

  // Next-state logic: latch the winner on grant, release on mem_resp.
  // NOTE: every signal gets a default first so no path leaves it unassigned;
  // otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    up_resp = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_BUSY;
          grant_d = winner;
          // Write wins when a port raises both strobes.
          wr_d    = up_write[winner];
          rd_d    = ~up_write[winner];
          wmask_d = up_wmask[winner*MASK_WIDTH +: MASK_WIDTH];
          addr_d  = up_address[winner*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = up_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      S_BUSY: begin
        if (mem_resp) begin
          state_d          = S_IDLE;
          rd_d             = 1'b0;
          wr_d             = 1'b0;
          up_resp[grant_q] = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched-request registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wmask_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy        = (state_q == S_BUSY);
  assign grant_id    = grant_q;
  assign mem_read    = rd_q;
  assign mem_write   = wr_q;
  assign mem_wmask   = wmask_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign up_rdata    = mem_rdata;

endmodule
